// File: rtl/pedal_pkg.sv
// Shared definitions for the pedal datapath: sample width, SPI state encoding,
// and the default SPI clock divider.
package pedal_pkg;

    localparam int SAMPLE_W    = 16;
    localparam int SPI_CLK_DIV = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } spi_state_t;

endpackage

// File: rtl/spi_codec_if_sync2.sv
// Generic two-flop synchroniser for bringing asynchronous inputs into the clk domain.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/spi_codec_if.sv
// Full-duplex SPI mode-0 master for the audio codec: one DAC word out and one
// ADC word in per accepted sample tick, MSB first, all SPI pins registered.
module spi_codec_if
    import pedal_pkg::*;
#(
    parameter int DATA_W   = SAMPLE_W,
    parameter int CLK_DIV  = SPI_CLK_DIV,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sample_tick,
    input  logic [DATA_W-1:0] dac_data,
    input  logic              spi_miso,
    output logic              spi_mosi,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic [DATA_W-1:0] adc_data,
    output logic              adc_valid,
    output logic              busy,
    output logic              overrun,
    input  logic              clr_overrun
);

    // One counter times the sclk half-periods and the CS setup/hold windows,
    // so it is sized for the longest of the three.
    localparam int CNT_MAX0 = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int CNT_MAX  = (CNT_MAX0 > CS_HOLD) ? CNT_MAX0 : CS_HOLD;
    localparam int CNT_W    = $clog2(CNT_MAX);
    localparam int BIT_W    = $clog2(DATA_W) + 1;

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [BIT_W-1:0] BITS_ALL   = BIT_W'(DATA_W);

    spi_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] adc_q, adc_d;
    logic              mosi_q, mosi_d;
    logic              sclk_q, sclk_d;
    logic              cs_n_q, cs_n_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic              miso_sync;
    logic              tick_en;
    logic              accept;

    sync2 #(.W(1)) u_miso_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (spi_miso),
        .q     (miso_sync)
    );

    assign tick_en = sample_tick & en;
    assign accept  = tick_en & (state_q == IDLE);

    // State register plus every registered output and datapath flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            adc_q   <= '0;
            mosi_q  <= 1'b0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            adc_q   <= adc_d;
            mosi_q  <= mosi_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state logic: sequence the frame phases and advance the counters.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                // The bit count advances on each fall; the frame ends after
                // the low half that follows the last fall.
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        bit_d = bit_q + 1'b1;
                    end else if (bit_q == BITS_ALL) begin
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the SPI pins, shift registers and status flags.
    always_comb begin
        tx_d    = tx_q;
        rx_d    = rx_q;
        adc_d   = adc_q;
        mosi_d  = mosi_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        valid_d = 1'b0;
        ovr_d   = ovr_q;
        if (clr_overrun) begin
            ovr_d = 1'b0;
        end
        if (tick_en && (state_q != IDLE)) begin
            ovr_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_d   = dac_data;
                    rx_d   = '0;
                    mosi_d = dac_data[DATA_W-1];
                    cs_n_d = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    sclk_d = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    if (sclk_q) begin
                        // Zero fill means mosi returns to 0 after the last bit.
                        sclk_d = 1'b0;
                        rx_d   = {rx_q[DATA_W-2:0], miso_sync};
                        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                        mosi_d = tx_q[DATA_W-2];
                    end else if (bit_q != BITS_ALL) begin
                        sclk_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cs_n_d  = 1'b1;
                    adc_d   = rx_q;
                    valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign spi_mosi  = mosi_q;
    assign spi_sclk  = sclk_q;
    assign spi_cs_n  = cs_n_q;
    assign adc_data  = adc_q;
    assign adc_valid = valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_spi_codec_if.sv
// Directed and randomized checks of spi_codec_if against a behavioural mode-0
// codec slave and latency/count expectations derived from the frame timing.
module tb_spi_codec_if;

    localparam int W   = 16;
    localparam int DIV = 4;
    localparam int SU  = 2;
    localparam int HO  = 2;
    localparam int LAT = 1 + SU + 2 * W * DIV + HO;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         sample_tick = 1'b0;
    logic         clr_overrun = 1'b0;
    logic [W-1:0] dac_data = '0;
    logic         spi_miso;
    logic         spi_mosi;
    logic         spi_sclk;
    logic         spi_cs_n;
    logic [W-1:0] adc_data;
    logic         adc_valid;
    logic         busy;
    logic         overrun;

    logic         loopback = 1'b0;
    logic         slave_miso;
    logic [W-1:0] slave_word = '0;
    logic [W-1:0] slave_rx = '0;
    int           nfalls = 0;

    int           total = 0;
    int           passed = 0;

    int unsigned  valid_cnt = 0;
    int unsigned  rise_cnt = 0;
    int unsigned  cs_low_cnt = 0;
    int unsigned  mosi_bad = 0;
    int unsigned  sclk_bad = 0;
    int unsigned  hi_run = 0;
    logic         prev_sclk = 1'b0;
    logic         prev_mosi = 1'b0;

    spi_codec_if #(
        .DATA_W   (W),
        .CLK_DIV  (DIV),
        .CS_SETUP (SU),
        .CS_HOLD  (HO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sample_tick (sample_tick),
        .dac_data    (dac_data),
        .spi_miso    (spi_miso),
        .spi_mosi    (spi_mosi),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .adc_data    (adc_data),
        .adc_valid   (adc_valid),
        .busy        (busy),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    // Mode-0 codec slave: presents its MSB while selected, moves to the next
    // bit after each sclk fall, and samples mosi on each sclk rise.
    always @(negedge spi_sclk or posedge spi_cs_n) begin
        if (spi_cs_n) nfalls <= 0;
        else          nfalls <= nfalls + 1;
    end
    assign slave_miso = (nfalls < W) ? slave_word[W-1-nfalls] : 1'b0;
    always @(posedge spi_sclk) slave_rx <= {slave_rx[W-2:0], spi_mosi};

    assign spi_miso = loopback ? spi_mosi : slave_miso;

    // Bus monitor: frame counts, sclk high-phase widths, mosi stability at rises.
    always @(negedge clk) begin
        if (!rst_n) begin
            hi_run    = 0;
            prev_sclk = 1'b0;
            prev_mosi = spi_mosi;
        end else begin
            if (adc_valid) valid_cnt++;
            if (!spi_cs_n) cs_low_cnt++;
            if (spi_sclk && !prev_sclk) begin
                rise_cnt++;
                if (spi_mosi !== prev_mosi) mosi_bad++;
            end
            if (spi_sclk) begin
                hi_run++;
            end else begin
                if (prev_sclk && hi_run != DIV) sclk_bad++;
                hi_run = 0;
            end
            prev_sclk = spi_sclk;
            prev_mosi = spi_mosi;
        end
    end

    initial begin
        #2ms;
        $error("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Issue one tick at the current negedge and return at the cycle adc_valid
    // is seen (or at the bound). dac_data is scrambled after acceptance.
    task automatic run_frame(input logic [W-1:0] d, input int drop_en_at, output int lat);
        sample_tick = 1'b1;
        dac_data    = d;
        @(negedge clk);
        sample_tick = 1'b0;
        dac_data    = W'($urandom);
        lat = 1;
        while (adc_valid !== 1'b1 && lat < 400) begin
            if (lat == drop_en_at) en = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pulse_tick();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    initial begin
        int unsigned  v0, r0, c0, m0, s0;
        int           lat;
        logic [W-1:0] d;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("reset cs_n",     spi_cs_n,  1'b1);
        check("reset sclk",     spi_sclk,  1'b0);
        check("reset mosi",     spi_mosi,  1'b0);
        check("reset adc_data", adc_data,  '0);
        check("reset valid",    adc_valid, 1'b0);
        check("reset busy",     busy,      1'b0);
        check("reset overrun",  overrun,   1'b0);

        // Loopback frame
        en = 1'b1;
        loopback = 1'b1;
        v0 = valid_cnt; r0 = rise_cnt; c0 = cs_low_cnt;
        run_frame(16'hA55A, 0, lat);
        check("loop latency",  lat,      LAT);
        check("loop adc_data", adc_data, 16'hA55A);
        check("loop busy in done", busy, 1'b1);
        @(negedge clk);
        check("loop valid pulse width", adc_valid, 1'b0);
        check("loop busy after",   busy, 1'b0);
        check("loop sclk pulses",  rise_cnt - r0,   W);
        check("loop cs_n low",     cs_low_cnt - c0, LAT - 1);
        check("loop valid count",  valid_cnt - v0,  1);

        // Codec slave frame
        loopback = 1'b0;
        slave_word = 16'h8001;
        m0 = mosi_bad;
        run_frame(16'h7FFE, 0, lat);
        check("codec latency",  lat,      LAT);
        check("codec adc_data", adc_data, 16'h8001);
        check("codec slave rx", slave_rx, 16'h7FFE);
        check("codec mosi stable at rise", mosi_bad - m0, 0);
        @(negedge clk);

        // Overrun: second tick 50 cycles into a frame
        v0 = valid_cnt;
        pulse_tick();
        repeat (49) @(negedge clk);
        pulse_tick();
        check("overrun set", overrun, 1'b1);
        repeat (250) @(negedge clk);
        check("overrun one frame", valid_cnt - v0, 1);
        check("overrun sticky", overrun, 1'b1);
        v0 = valid_cnt;
        pulse_tick();
        repeat (49) @(negedge clk);
        clr_overrun = 1'b1;
        sample_tick = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        sample_tick = 1'b0;
        check("overrun set beats clear", overrun, 1'b1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("overrun cleared", overrun, 1'b0);
        repeat (250) @(negedge clk);
        check("overrun second frame count", valid_cnt - v0, 1);

        // Reset during the 8th bit
        pulse_tick();
        repeat (61) @(negedge clk);
        check("pre-reset busy", busy, 1'b1);
        v0 = valid_cnt;
        rst_n = 1'b0;
        #1;
        check("mid-reset cs_n", spi_cs_n, 1'b1);
        check("mid-reset sclk", spi_sclk, 1'b0);
        check("mid-reset busy", busy,     1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("no valid after reset", valid_cnt - v0, 0);
        loopback = 1'b1;
        d = W'($urandom);
        run_frame(d, 0, lat);
        check("post-reset latency",  lat,      LAT);
        check("post-reset adc_data", adc_data, d);
        @(negedge clk);

        // en gating
        en = 1'b0;
        v0 = valid_cnt; c0 = cs_low_cnt;
        repeat (3) begin
            pulse_tick();
            repeat (20) @(negedge clk);
        end
        repeat (150) @(negedge clk);
        check("en=0 no frame",   valid_cnt - v0,  0);
        check("en=0 cs_n idle",  cs_low_cnt - c0, 0);
        check("en=0 no overrun", overrun,         1'b0);
        en = 1'b1;
        d = W'($urandom);
        run_frame(d, 20, lat);
        check("en drop latency",  lat,      LAT);
        check("en drop adc_data", adc_data, d);
        en = 1'b1;
        @(negedge clk);

        // Back-to-back random frames against the codec slave
        loopback = 1'b0;
        v0 = valid_cnt; m0 = mosi_bad; s0 = sclk_bad;
        for (int i = 0; i < 100; i++) begin
            slave_word = W'($urandom);
            d = W'($urandom);
            run_frame(d, 0, lat);
            check("b2b latency",  lat,      LAT);
            check("b2b adc_data", adc_data, slave_word);
            check("b2b slave rx", slave_rx, d);
            @(negedge clk);
        end
        check("b2b no overrun",   overrun,         1'b0);
        check("b2b frame count",  valid_cnt - v0,  100);
        check("b2b mosi stable",  mosi_bad - m0,   0);
        check("b2b sclk width",   sclk_bad - s0,   0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
